// File: rtl/ofm_requant_pkg.sv
// Shared types, constants and width helpers for the output requantizer.
package ofm_requant_pkg;

    localparam int KERNEL_NUM_DEF       = 2;
    localparam int FETCH_KERNEL_NUM_DEF = 8;
    localparam int OC                   = KERNEL_NUM_DEF * FETCH_KERNEL_NUM_DEF;
    localparam int OC_W                 = $clog2(OC);

    // Full-precision product of a saturated 32-bit word and a 16-bit multiplier.
    typedef logic signed [47:0] prod_t;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Collapse a 33-bit signed sum back into signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [32:0] x);
        if (x[32] != x[31]) begin
            return x[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
        return x[31:0];
    endfunction

endpackage

// File: rtl/ofm_requant_pipe.sv
// Three-stage requant datapath: bias add, multiply, round/ReLU/clamp.
// All stages move together on a single advance so a stalled output freezes
// the whole pipe and nothing is dropped.
module requant_pipe
    import ofm_requant_pkg::*;
#(
    parameter int MULT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    input  logic signed [31:0]       acc_i,
    input  logic signed [31:0]       bias_i,
    input  logic signed [MULT_W-1:0] mult_i,
    input  logic        [4:0]        shift_i,
    input  logic                     relu_i,
    input  logic                     ofm_ready_i,
    output logic                     adv_o,
    output logic                     empty_o,
    output logic        [7:0]        ofm_o,
    output logic                     ofm_valid_o,
    output logic                     sat_o
);

    localparam logic signed [48:0] R_MAX = 49'(INT8_MAX);
    localparam logic signed [48:0] R_MIN = 49'(INT8_MIN);

    logic                     v1_q, v2_q, v3_q;
    logic signed [31:0]       b_q;
    logic signed [MULT_W-1:0] m1_q;
    logic        [4:0]        sh1_q, sh2_q;
    logic                     relu1_q, relu2_q;
    prod_t                    p_q;
    logic        [7:0]        ofm_q;
    logic                     sat_q;

    logic signed [32:0]       sum;
    logic signed [31:0]       b_d;
    prod_t                    p_d;
    logic signed [48:0]       p_ext, rnd, r;
    logic        [7:0]        y_d;
    logic                     sat_d;

    assign adv_o       = !v3_q || ofm_ready_i;
    assign empty_o     = !(v1_q || v2_q || v3_q);
    assign ofm_o       = ofm_q;
    assign ofm_valid_o = v3_q;
    assign sat_o       = sat_q;

    // Stage arithmetic: saturating bias add, signed product, round-half-up shift then clamp.
    always_comb begin
        sum   = {acc_i[31], acc_i} + {bias_i[31], bias_i};
        b_d   = sat32(sum);
        p_d   = prod_t'(b_q) * prod_t'(m1_q);
        p_ext = 49'(p_q);
        rnd   = p_ext;
        if (sh2_q != 5'd0) begin
            rnd = p_ext + (49'sd1 <<< (sh2_q - 5'd1));
        end
        r = rnd >>> sh2_q;
        if (relu2_q && r[48]) begin
            r = '0;
        end
        sat_d = 1'b0;
        y_d   = r[7:0];
        if (r > R_MAX) begin
            y_d   = 8'(INT8_MAX);
            sat_d = 1'b1;
        end else if (r < R_MIN) begin
            y_d   = 8'(INT8_MIN);
            sat_d = 1'b1;
        end
    end

    // Pipeline registers, all gated by the shared advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            b_q     <= '0;
            m1_q    <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            relu1_q <= 1'b0;
            relu2_q <= 1'b0;
            p_q     <= '0;
            ofm_q   <= '0;
            sat_q   <= 1'b0;
        end else if (adv_o) begin
            v1_q    <= in_valid_i;
            b_q     <= b_d;
            m1_q    <= mult_i;
            sh1_q   <= shift_i;
            relu1_q <= relu_i;
            v2_q    <= v1_q;
            p_q     <= p_d;
            sh2_q   <= sh1_q;
            relu2_q <= relu1_q;
            v3_q    <= v2_q;
            ofm_q   <= y_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: rtl/ofm_requant.sv
// Output requantizer top: frame FSM, channel walk, per-channel config and saturation count.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for start; config writes accepted
//   RUN     | accepting accumulator words until cnt reaches 0
//   DRAIN   | input closed, waiting for the pipe to empty
module ofm_requant
    import ofm_requant_pkg::*;
#(
    parameter int KERNEL_NUM       = KERNEL_NUM_DEF,
    parameter int PE_COLS          = 8,
    parameter int FETCH_KERNEL_NUM = FETCH_KERNEL_NUM_DEF,
    parameter int MULT_W           = 16,
    parameter int LEN_W            = 16
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              cfg_we,
    input  logic [$clog2(KERNEL_NUM*FETCH_KERNEL_NUM)-1:0]    cfg_addr,
    input  logic [31:0]                                       cfg_bias,
    input  logic [MULT_W-1:0]                                 cfg_mult,
    input  logic [4:0]                                        cfg_shift,
    input  logic                                              relu_en,
    input  logic                                              start,
    input  logic [LEN_W-1:0]                                  frame_len,
    input  logic [31:0]                                       acc_in,
    input  logic                                              acc_valid,
    output logic                                              acc_ready,
    output logic [7:0]                                        ofm,
    output logic                                              ofm_valid,
    input  logic                                              ofm_ready,
    output logic                                              busy,
    output logic                                              done,
    output logic [15:0]                                       sat_cnt
);

    localparam int OC_L  = KERNEL_NUM * FETCH_KERNEL_NUM;
    localparam int CH_W  = $clog2(OC_L);
    localparam int G     = PE_COLS * KERNEL_NUM;
    localparam int WIG_W = $clog2(G);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_base_q, ch_base_d;
    logic [WIG_W-1:0]  wig_q, wig_d;
    logic              relu_q, relu_d;
    logic              done_q, done_d;
    logic [15:0]       sat_cnt_q;

    logic signed [31:0]       bias_q  [OC_L];
    logic signed [MULT_W-1:0] mult_q  [OC_L];
    logic        [4:0]        shift_q [OC_L];

    logic              adv, pipe_empty, accept, sat_flag;
    logic [CH_W-1:0]   ch;
    logic [CH_W:0]     base_sum;

    assign acc_ready = adv && (state_q == S_RUN);
    assign accept    = acc_valid && acc_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign sat_cnt   = sat_cnt_q;

    // Channel of the current word: group base plus which PE column block it falls in.
    always_comb begin
        ch       = ch_base_q + CH_W'(32'(wig_q) / PE_COLS);
        base_sum = {1'b0, ch_base_q} + (CH_W+1)'(KERNEL_NUM);
    end

    // Frame FSM; counters move only on an accepted word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_base_d = ch_base_q;
        wig_d     = wig_q;
        relu_d    = relu_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    relu_d = relu_en;
                    if (frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        cnt_d     = frame_len;
                        ch_base_d = '0;
                        wig_d     = '0;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (wig_q == WIG_W'(G - 1)) begin
                        wig_d = '0;
                        if (base_sum >= (CH_W+1)'(OC_L)) begin
                            ch_base_d = CH_W'(base_sum - (CH_W+1)'(OC_L));
                        end else begin
                            ch_base_d = base_sum[CH_W-1:0];
                        end
                    end else begin
                        wig_d = wig_q + WIG_W'(1);
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_base_q <= '0;
            wig_q     <= '0;
            relu_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_base_q <= ch_base_d;
            wig_q     <= wig_d;
            relu_q    <= relu_d;
            done_q    <= done_d;
        end
    end

    // Per-channel config; writes outside IDLE are dropped so a frame sees stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OC_L; i++) begin
                bias_q[i]  <= '0;
                mult_q[i]  <= '0;
                shift_q[i] <= '0;
            end
        end else if (cfg_we && (state_q == S_IDLE)) begin
            bias_q[cfg_addr]  <= cfg_bias;
            mult_q[cfg_addr]  <= cfg_mult;
            shift_q[cfg_addr] <= cfg_shift;
        end
    end

    // Saturation count, counted once per delivered byte and cleared on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            sat_cnt_q <= '0;
        end else if (ofm_valid && ofm_ready && sat_flag && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    requant_pipe #(
        .MULT_W (MULT_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (accept),
        .acc_i       (acc_in),
        .bias_i      (bias_q[ch]),
        .mult_i      (mult_q[ch]),
        .shift_i     (shift_q[ch]),
        .relu_i      (relu_q),
        .ofm_ready_i (ofm_ready),
        .adv_o       (adv),
        .empty_o     (pipe_empty),
        .ofm_o       (ofm),
        .ofm_valid_o (ofm_valid),
        .sat_o       (sat_flag)
    );

endmodule

// File: tb/tb_ofm_requant.sv
// Scoreboard bench for ofm_requant: driver pushes model results, monitor pops on each output.
module tb_ofm_requant;
    import ofm_requant_pkg::*;

    localparam int KN = 2;
    localparam int PC = 8;
    localparam int G  = KN * PC;

    logic             clk, rst_n;
    logic             cfg_we;
    logic [OC_W-1:0]  cfg_addr;
    logic [31:0]      cfg_bias;
    logic [15:0]      cfg_mult;
    logic [4:0]       cfg_shift;
    logic             relu_en, start;
    logic [15:0]      frame_len;
    logic [31:0]      acc_in;
    logic             acc_valid, acc_ready;
    logic [7:0]       ofm;
    logic             ofm_valid, ofm_ready;
    logic             busy, done;
    logic [15:0]      sat_cnt;

    ofm_requant dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .relu_en(relu_en), .start(start), .frame_len(frame_len),
        .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .ofm(ofm), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .busy(busy), .done(done), .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] val;
        bit         sat;
        int         acc_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         stim_q[$];
    int         checks = 0, failures = 0;
    int         tb_bias[OC], tb_mult[OC], tb_shift[OC];
    bit         frame_relu;
    int         exp_sat, out_cnt, done_cnt;
    int         stall_req = 0;
    bit         rand_ready = 0, lat_chk = 0;
    int         valid_pct = 100;
    logic [7:0] last_ofm;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic straight from the requant rules.
    function automatic void model(input int acc, input int b, input int m, input int sh,
                                  input bit relu, output logic [7:0] o, output bit s);
        longint sum, p, r;
        sum = longint'(acc) + longint'(b);
        if (sum > 64'sd2147483647)  sum = 64'sd2147483647;
        if (sum < -64'sd2147483648) sum = -64'sd2147483648;
        p = sum * longint'(m);
        if (sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = p;
        if (relu && r < 0) r = 0;
        s = 1'b0;
        if (r > 127)  begin r = 127;  s = 1'b1; end
        if (r < -128) begin r = -128; s = 1'b1; end
        o = r[7:0];
    endfunction

    task automatic cfg(input int c, input int b, input int m, input int s);
        cfg_we = 1'b1; cfg_addr = OC_W'(c); cfg_bias = b; cfg_mult = 16'(m); cfg_shift = 5'(s);
        tick();
        cfg_we = 1'b0;
        tb_bias[c] = b; tb_mult[c] = m; tb_shift[c] = s;
    endtask

    // Monitor: pops the scoreboard on every delivered byte and checks hold-while-stalled.
    initial begin
        exp_t       e;
        logic [7:0] prev_ofm;
        bit         prev_stall;
        prev_stall = 1'b0;
        prev_ofm   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_stall) begin
                    chk("hold_valid", ofm_valid, 1);
                    chk("hold_ofm", ofm, prev_ofm);
                end
                if (ofm_valid && ofm_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output actual=%0d required=none", ofm);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ofm", ofm, e.val);
                        if (lat_chk) chk("latency", cyc - e.acc_cyc, 3);
                        if (e.sat && exp_sat < 65535) exp_sat++;
                        out_cnt++;
                        last_ofm = ofm;
                    end
                end
                prev_stall = ofm_valid && !ofm_ready;
                prev_ofm   = ofm;
            end
        end
    end

    // Output-side ready: forced stall window, random, or always ready.
    initial begin
        ofm_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req > 0) begin
                ofm_ready = 1'b0;
                stall_req--;
            end else if (rand_ready) begin
                ofm_ready = ($urandom_range(0, 3) != 0);
            end else begin
                ofm_ready = 1'b1;
            end
        end
    end

    task automatic run_frame(input int len, input bit relu, input int stall_at = -1,
                             input int disturb_at = -1);
        int         budget, ch;
        bit         ok;
        logic [7:0] o;
        bit         s;
        start = 1'b1; frame_len = 16'(len); relu_en = relu;
        tick();
        start = 1'b0;
        frame_relu = relu; exp_sat = 0; done_cnt = 0; out_cnt = 0;
        for (int n = 0; n < len; n++) begin
            while (valid_pct < 100 && $urandom_range(0, 99) >= valid_pct) begin
                acc_valid = 1'b0;
                tick();
            end
            if (n == stall_at) stall_req = 5;
            if (n == disturb_at) begin
                cfg_we = 1'b1; cfg_addr = '0; cfg_bias = 32'd999; cfg_mult = 16'd5;
                cfg_shift = 5'd0; start = 1'b1; frame_len = 16'd5;
            end
            acc_valid = 1'b1;
            acc_in    = (n < stim_q.size()) ? stim_q[n] : 0;
            budget = 0; ok = 1'b0;
            forever begin
                @(negedge clk);
                if (acc_ready) begin ok = 1'b1; break; end
                budget++;
                if (budget > 1000) begin
                    checks++; failures++;
                    $display("FAIL accept_timeout actual=%0d required=%0d", n, len);
                    break;
                end
            end
            if (ok) begin
                ch = ((n / G) * KN + (n % G) / PC) % OC;
                model(int'(acc_in), tb_bias[ch], tb_mult[ch], tb_shift[ch], frame_relu, o, s);
                sb_q.push_back('{o, s, cyc});
            end
            tick();
            cfg_we = 1'b0; start = 1'b0;
        end
        acc_valid = 1'b0;
        for (int k = 0; k < 500 && done_cnt == 0; k++) @(negedge clk);
        tick(); tick();
        chk("done_once", done_cnt, 1);
        chk("out_count", out_cnt, len);
        chk("sb_drained", sb_q.size(), 0);
        chk("sat_cnt", sat_cnt, exp_sat);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        logic signed [15:0] m16;
        #500_000;
        m16 = '0;
        $display("FAIL global_timeout actual=%0d required=finish", cyc + int'(m16));
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [15:0] m16;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0;
        cfg_shift = '0; relu_en = 1'b0; start = 1'b0; frame_len = '0; acc_in = '0;
        acc_valid = 1'b0;
        for (int c = 0; c < OC; c++) begin tb_bias[c] = 0; tb_mult[c] = 0; tb_shift[c] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_ofm", ofm, 0);
        chk("rst_ofm_valid", ofm_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Identity and saturation, with latency tracking.
        for (int c = 0; c < OC; c++) cfg(c, 0, 1, 0);
        stim_q = '{100, 300, -200};
        lat_chk = 1'b1;
        run_frame(3, 1'b0);
        lat_chk = 1'b0;
        chk("ident_sat_cnt", sat_cnt, 2);
        chk("ident_last", last_ofm, 8'h80);

        // Rounding.
        cfg(0, 0, 3, 2);
        stim_q = '{5, -5, 6};
        run_frame(3, 1'b0);
        chk("round_last", last_ofm, 5);
        cfg(0, -10, 7, 2);
        stim_q = '{10};
        run_frame(1, 1'b0);
        chk("bias_cancel", last_ofm, 0);

        // ReLU before clamp.
        cfg(0, 0, 1, 0);
        stim_q = '{-5};
        run_frame(1, 1'b1);
        chk("relu_on", last_ofm, 0);
        chk("relu_sat", sat_cnt, 0);
        run_frame(1, 1'b0);
        chk("relu_off", last_ofm, 8'hFB);

        // Channel walk, then a longer frame that wraps the channel base.
        for (int c = 0; c < OC; c++) cfg(c, 10 * c, 1, 0);
        stim_q.delete();
        for (int i = 0; i < 32; i++) stim_q.push_back(0);
        run_frame(32, 1'b0);
        chk("walk_last", last_ofm, 30);
        stim_q.delete();
        for (int i = 0; i < 144; i++) stim_q.push_back($urandom_range(0, 40) - 20);
        valid_pct = 70; rand_ready = 1'b1;
        run_frame(144, 1'b0);

        // Random full-range and moderate-range configurations.
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < OC; c++) begin
                m16 = 16'($urandom());
                if (f == 0) cfg(c, int'($urandom()), int'(m16), $urandom_range(0, 31));
                else cfg(c, $urandom_range(0, 2000) - 1000, $urandom_range(0, 600) - 300,
                         $urandom_range(0, 12));
            end
            stim_q.delete();
            for (int i = 0; i < 60; i++) begin
                if (f == 0) stim_q.push_back(int'($urandom()));
                else stim_q.push_back($urandom_range(0, 10000) - 5000);
            end
            valid_pct = 60;
            run_frame(60, 1'($urandom_range(0, 1)));
        end

        // Backpressure: a forced 5-cycle stall mid-stream.
        rand_ready = 1'b0; valid_pct = 50;
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back($urandom_range(0, 4000) - 2000);
        run_frame(20, 1'b0, 8);

        // Config write and start during RUN must be ignored.
        valid_pct = 100;
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back($urandom_range(0, 4000) - 2000);
        run_frame(10, 1'b0, -1, 4);

        // Zero-length frame.
        start = 1'b1; frame_len = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        @(negedge clk);
        chk("zero_len_pulse", done, 0);
        tick();

        // Reset mid-frame discards the pipe and clears config.
        start = 1'b1; frame_len = 16'd20; relu_en = 1'b0;
        tick();
        start = 1'b0; acc_valid = 1'b1; acc_in = 32'd7;
        tick(); tick();
        rst_n = 1'b0; acc_valid = 1'b0;
        #2;
        chk("mid_rst_acc_ready", acc_ready, 0);
        chk("mid_rst_ofm_valid", ofm_valid, 0);
        chk("mid_rst_ofm", ofm, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sat_cnt", sat_cnt, 0);
        sb_q.delete();
        for (int c = 0; c < OC; c++) begin tb_bias[c] = 0; tb_mult[c] = 0; tb_shift[c] = 0; end
        tick();
        rst_n = 1'b1;
        tick();
        stim_q = '{50, -50, 1000, 3};
        run_frame(4, 1'b0);
        for (int c = 0; c < OC; c++) cfg(c, c, 2, 1);
        stim_q.delete();
        for (int i = 0; i < 24; i++) stim_q.push_back($urandom_range(0, 300) - 150);
        run_frame(24, 1'b0);

        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofm_requant.md
# ofm_requant

Output requantizer that sits directly downstream of the convolution accelerator's 32-bit `out` / `out_valid` / `out_ready` port. It accepts raw signed 32-bit accumulator words in the accelerator's drain order and adds a per-output-channel bias. It then scales by a per-channel fixed-point multiplier with a rounding right shift, optionally applies ReLU, and saturates to int8. The result is an 8-bit valid/ready byte stream with the same format as the accelerator's `ifm` input, so it can feed the next layer.

## Interface
Parameters:
- `KERNEL_NUM`, 2: kernels per PE pass; channels advanced per drain group.
- `PE_COLS`, 8: consecutive words per channel within a group.
- `FETCH_KERNEL_NUM`, 8: passes per layer. Output channel count is `OC = KERNEL_NUM*FETCH_KERNEL_NUM`.
- `MULT_W`, 16: signed multiplier width.
- `LEN_W`, 16: frame length counter width.

Ports:
- Reset: `rst_n`, asynchronous, active-low. Clock: `clk`.
- `clk  in  1`  clock.
- `rst_n  in  1`  async active-low reset.
- `cfg_we  in  1`  write channel config; honoured only in IDLE.
- `cfg_addr  in  $clog2(OC)`  channel index.
- `cfg_bias  in  32`  signed bias.
- `cfg_mult  in  MULT_W`  signed multiplier.
- `cfg_shift  in  5`  right shift, 0..31.
- `relu_en  in  1`  clamp negatives to 0; sampled at `start`.
- `start  in  1`  begin frame; honoured only in IDLE.
- `frame_len  in  LEN_W`  words in frame; sampled at `start`; 0 means `done` is raised immediately.
- `acc_in  in  32`  signed accumulator word.
- `acc_valid  in  1`  / `acc_ready  out  1`  input handshake.
- `ofm  out  8`  int8 result.
- `ofm_valid  out  1`  / `ofm_ready  in  1`  output handshake.
- `busy  out  1`  state ≠ IDLE.
- `done  out  1`  one-cycle pulse at frame end.
- `sat_cnt  out  16`  count of clamped results, saturating at 0xFFFF, cleared at `start`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start` with `frame_len≠0`. Loads `cnt=frame_len` and the channel pointer `ch_base=0`.
  - `start` with `frame_len=0` pulses `done` the next cycle and stays in IDLE.
  - RUN → DRAIN when the last word is accepted (`cnt` reaches 0).
  - DRAIN → IDLE when pipeline stages are all empty; `done` pulses in that transition cycle.
- Channel selection: word index `w` within a group of `G=PE_COLS*KERNEL_NUM` words gives `ch = ch_base + w/PE_COLS`.
  - After each full group, `ch_base += KERNEL_NUM`, modulo `OC`.
  - A partial final group is legal.
- Config registers (bias, mult, shift per channel) reset to 0 and keep their values across frames. A `cfg_we` outside IDLE is dropped.
- Arithmetic:
  - S1: `b = sat32(acc_in + bias[ch])`, 33-bit add then saturate to signed 32.
  - S2: `p = b * mult[ch]`, signed, 48 bits.
  - S3: if `shift>0`, `r = (p + (1<<(shift-1))) >>> shift`, otherwise `r = p`.
    - If `relu_en` and `r<0`, set `r=0`.
    - `ofm = clamp(r, -128, 127)`; `sat_cnt` increments when the clamp changes the value.
- ReLU is applied before the clamp, so a negative value under ReLU does not count as saturation.

## Timing
- Reset values: `acc_ready=0`, `ofm=0`, `ofm_valid=0`, `busy=0`, `done=0`, `sat_cnt=0`; state IDLE; all stage valids 0.
- Pipeline: 3 stages with a single global advance, `adv = !v3 | ofm_ready`. `acc_ready = adv & (state==RUN)`.
- Latency: 3 cycles from `acc_valid&acc_ready` to `ofm_valid` when `ofm_ready` is held high. Throughput is 1 word per cycle.
- `ofm` and `ofm_valid` are registered and hold stable while `ofm_valid & !ofm_ready`. No word is dropped or duplicated.
- Channel pointer, word-in-group counter and `cnt` advance only on an accepted input word.
- Reset mid-frame returns to IDLE immediately and discards pipeline contents. Config registers return to 0.

## Structure
- Shared package `ofm_requant_pkg` holds:
  - `OC` and its index width;
  - the 48-bit product type;
  - constants `INT8_MAX=127` and `INT8_MIN=-128`;
  - the `sat32` width rule.
- One sub-module, `requant_pipe`: the 3-stage arithmetic datapath with the `adv` stall. Inputs are word, bias, mult, shift and relu; outputs are int8 plus a saturation flag.
- The top level holds the FSM, counters, config register file and `sat_cnt`.

## Test plan
- Identity and saturation:
  - Setup: bias=0, mult=1, shift=0, relu off.
  - Inputs 100, 300, -200 → `ofm` 100, 127, -128; `sat_cnt=2`.
- Rounding:
  - Setup: mult=3, shift=2.
  - Inputs 5, -5, 6 → 4, -4, 5.
  - Setup: bias=-10, input 10, mult=7 → 0.
- ReLU:
  - Input -5 with `relu_en=1` → 0, and `sat_cnt` unchanged.
  - Same input with `relu_en=0` → 0xFB.
- Channel walk:
  - Setup: defaults; bias[c]=10*c for c=0..15, mult=1, shift=0; `frame_len=32`, all inputs 0.
  - Output: 8×0, 8×10, 8×20, 8×30.
  - After 8 groups `ch_base` wraps to 0.
- Backpressure:
  - `frame_len=20`, random `acc_valid`, `ofm_ready` low for 5 cycles mid-stream.
  - All 20 results appear in order; `ofm` stays stable while stalled; `done` pulses once after the last output.
- Control edges:
  - `cfg_we` and `start` during RUN are ignored.
  - `start` with `frame_len=0` → `done` on the next cycle.
  - `rst_n` low mid-frame → all outputs at reset values, and a new frame runs correctly afterwards.
